// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// carried on the two-bit mode input.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage : usr_pkg

// File: rtl/usr_bit_counter.sv
// Counts shifts within a word, wraps at DATA_WIDTH-1 and emits a registered
// one-cycle word_done pulse on the wrap. A load restarts the word.
module usr_bit_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             shift,
    input  logic             load,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_done
);

    // Compare against DATA_WIDTH-1, not the counter's all-ones value, so
    // non-power-of-two widths wrap at the right place.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (en) begin
                if (load) begin
                    bit_cnt <= '0;
                end else if (shift) begin
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt   <= '0;
                        word_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule : usr_bit_counter

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// with a per-word shift counter and completed-word pulse.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  sin_r,
    input  logic                  sin_l,
    input  logic [DATA_WIDTH-1:0] pin,
    output logic [DATA_WIDTH-1:0] pout,
    output logic                  sout_r,
    output logic                  sout_l,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic                  word_done
);

    mode_e                 mode_sel;
    logic                  is_shift;
    logic                  is_load;
    logic [DATA_WIDTH-1:0] q;

    always_comb begin
        mode_sel = mode_e'(mode);
        is_shift = (mode_sel == MODE_SHR) || (mode_sel == MODE_SHL);
        is_load  = (mode_sel == MODE_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            case (mode_sel)
                MODE_SHR:  q <= {sin_r, q[DATA_WIDTH-1:1]};
                MODE_SHL:  q <= {q[DATA_WIDTH-2:0], sin_l};
                MODE_LOAD: q <= pin;
                default:   q <= q;
            endcase
        end
    end

    usr_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .shift     (is_shift),
        .load      (is_load),
        .bit_cnt   (bit_cnt),
        .word_done (word_done)
    );

    // Serial and parallel outputs come straight off the register.
    assign pout   = q;
    assign sout_r = q[0];
    assign sout_l = q[DATA_WIDTH-1];

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register at widths 8 and 5, checked against an
// arithmetic model of the register value and shifts-per-word count.
module tb_universal_shift_register;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] pin8;
    logic [4:0] pin5;

    logic [7:0] pout8;
    logic       sout_r8, sout_l8, wd8;
    logic [2:0] bc8;
    logic [4:0] pout5;
    logic       sout_r5, sout_l5, wd5;
    logic [2:0] bc5;

    int checks = 0;
    int errors = 0;

    longint unsigned mq8 = 0, mq5 = 0;
    int              msh8 = 0, msh5 = 0;
    bit              mdone8 = 0, mdone5 = 0;

    logic exp_q[$];

    universal_shift_register #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pin(pin8), .pout(pout8), .sout_r(sout_r8), .sout_l(sout_l8),
        .bit_cnt(bc8), .word_done(wd8)
    );

    universal_shift_register #(.DATA_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pin(pin5), .pout(pout5), .sout_r(sout_r5), .sout_l(sout_l5),
        .bit_cnt(bc5), .word_done(wd5)
    );

    // Clock and reset-state block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the register is a number; shifting right halves it and
    // adds the new bit's weight at the top, shifting left doubles it modulo
    // 2^w and adds the new bit. sh counts shifts taken in the current word.
    task automatic model_step(input int w, inout longint unsigned q, inout int sh,
                              inout bit done, input logic r, input logic e,
                              input logic [1:0] m, input logic sr, input logic sl,
                              input longint unsigned p);
        longint unsigned full;
        full = 64'd1 << w;
        if (r) begin
            q = 0; sh = 0; done = 0;
        end else if (!e || m == 2'd0) begin
            done = 0;
        end else if (m == 2'd3) begin
            q = p % full; sh = 0; done = 0;
        end else begin
            if (m == 2'd1) q = q / 2 + longint'(sr) * (full / 2);
            else           q = (q * 2) % full + longint'(sl);
            sh++;
            done = (sh == w);
            if (done) sh = 0;
        end
    endtask

    // Driver: apply inputs, take one edge, advance the model, compare all outputs.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [7:0] p);
        rst = r; en = e; mode = m; sin_r = sr; sin_l = sl;
        pin8 = p; pin5 = p[4:0];
        @(posedge clk);
        model_step(8, mq8, msh8, mdone8, r, e, m, sr, sl, 64'(p));
        model_step(5, mq5, msh5, mdone5, r, e, m, sr, sl, 64'(p[4:0]));
        #1;
        check("pout8",   64'(pout8),   mq8);
        check("sout_r8", 64'(sout_r8), mq8 % 2);
        check("sout_l8", 64'(sout_l8), (mq8 >> 7) % 2);
        check("bit_cnt8", 64'(bc8),    64'(msh8));
        check("word_done8", 64'(wd8),  64'(mdone8));
        check("pout5",   64'(pout5),   mq5);
        check("sout_r5", 64'(sout_r5), mq5 % 2);
        check("sout_l5", 64'(sout_l5), (mq5 >> 4) % 2);
        check("bit_cnt5", 64'(bc5),    64'(msh5));
        check("word_done5", 64'(wd5),  64'(mdone5));
    endtask

    initial begin
        logic [7:0] pat;
        int         pulses;
        int         max_bc;
        int         pulse_at;
        logic       b;

        rst = 1'b1; en = 1'b0; mode = 2'd0; sin_r = 1'b0; sin_l = 1'b0;
        pin8 = '0; pin5 = '0;
        step(1, 0, 2'd0, 0, 0, 8'h00);
        step(1, 1, 2'd2, 1, 1, 8'h00);

        // Load all-ones, then reset clears everything.
        step(0, 1, 2'd3, 0, 0, 8'hFF);
        check("load_ff", 64'(pout8), 64'hFF);
        step(1, 1, 2'd3, 0, 0, 8'hFF);
        check("rst_pout", 64'(pout8), 64'h00);
        check("rst_bc",   64'(bc8),   64'd0);
        check("rst_wd",   64'(wd8),   64'd0);

        // Serial-in right: pattern 1,0,1,1,0,0,1,0 then more random bits.
        pat = 8'b0100_1101;
        pulses = 0;
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            b = (i < 8) ? pat[i] : 1'($urandom_range(0, 1));
            step(0, 1, 2'd1, b, 0, 8'h00);
            exp_q.push_back(b);
            if (exp_q.size() == 8) check("sout_r_lat", 64'(sout_r8), 64'(exp_q.pop_front()));
            if (wd8) pulses++;
            if (i == 7) begin
                check("siso_pout", 64'(pout8), 64'h4D);
                check("siso_wd",   64'(wd8),   64'd1);
                check("siso_first_bit", 64'(sout_r8), 64'd1);
            end
            if (i == 8) check("siso_wd_clear", 64'(wd8), 64'd0);
        end
        check("siso_pulses", 64'(pulses), 64'd1);

        // Serial-in left latency toward sout_l.
        step(1, 0, 2'd0, 0, 0, 8'h00);
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            b = 1'($urandom_range(0, 1));
            step(0, 1, 2'd2, 0, b, 8'h00);
            exp_q.push_back(b);
            if (exp_q.size() == 8) check("sout_l_lat", 64'(sout_l8), 64'(exp_q.pop_front()));
        end

        // Load, left shifts, reload.
        step(0, 1, 2'd3, 0, 0, 8'hA5);
        for (int i = 0; i < 3; i++) step(0, 1, 2'd2, 1, 0, 8'h00);
        check("shl_pout", 64'(pout8), 64'h28);
        check("shl_bc",   64'(bc8),   64'd3);
        step(0, 1, 2'd3, 0, 0, 8'h3C);
        check("reload_bc", 64'(bc8), 64'd0);
        check("reload_pout", 64'(pout8), 64'h3C);

        // Enable toggling every cycle: only enabled edges count.
        step(1, 0, 2'd0, 0, 0, 8'h00);
        pulses = 0; pulse_at = -1;
        for (int i = 0; i < 18; i++) begin
            step(0, (i % 2 == 0), 2'd1, 1'($urandom_range(0, 1)), 0, 8'h00);
            if (wd8) begin pulses++; pulse_at = i; end
        end
        check("en_pulses", 64'(pulses), 64'd1);
        check("en_pulse_at", 64'(pulse_at), 64'd14);

        // Load on the edge that would wrap the count.
        step(1, 0, 2'd0, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 1, 2'd2, 0, 1, 8'h00);
        check("pre_wrap_bc", 64'(bc8), 64'd7);
        step(0, 1, 2'd3, 0, 0, 8'h5A);
        check("collide_wd", 64'(wd8), 64'd0);
        check("collide_bc", 64'(bc8), 64'd0);

        // Reset mid-word discards it.
        for (int i = 0; i < 5; i++) step(0, 1, 2'd1, 1, 0, 8'h00);
        check("mid_bc", 64'(bc8), 64'd5);
        step(1, 1, 2'd1, 1, 0, 8'h00);
        check("midrst_bc", 64'(bc8), 64'd0);
        check("midrst_wd", 64'(wd8), 64'd0);
        step(0, 1, 2'd1, 1, 0, 8'h00);
        check("post_rst_bc", 64'(bc8), 64'd1);
        check("post_rst_wd", 64'(wd8), 64'd0);

        // Width 5: ten right shifts give exactly two pulses.
        step(1, 0, 2'd0, 0, 0, 8'h00);
        pulses = 0; max_bc = 0;
        for (int i = 0; i < 11; i++) begin
            step(0, 1, (i < 10) ? 2'd1 : 2'd0, 1'($urandom_range(0, 1)), 0, 8'h00);
            if (wd5) pulses++;
            if (int'(bc5) > max_bc) max_bc = int'(bc5);
        end
        check("w5_pulses", 64'(pulses), 64'd2);
        check("w5_max_bc_ok", 64'(max_bc <= 4), 64'd1);

        // Randomised traffic on both widths.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_universal_shift_register
